// File: rtl/sseg_mux_nx.sv
// sseg_mux_nx -- N-digit multiplexed seven-segment display driver.
//
// Time-multiplexes a packed hex value onto active-low segment/anode pins.
// The display reads only shadow copies of value/dp_in/blank_lz, which are
// refreshed once per frame (and once right after reset), so a frame is
// always drawn from one coherent snapshot. Also provides leading-zero
// blanking, PWM brightness and a dead time at the start of every digit slot
// to avoid ghosting between neighbouring digits.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   btnC        asynchronous active-high reset
//   value       packed hex nibbles, nibble k drives digit k (0 = rightmost)
//   dp_in       per-digit decimal point request, 1 = lit
//   blank_lz    1 = suppress leading zeros
//   brightness  PWM level, 0 = dark, all-ones = full on (sampled live)
//   seg         cathodes g..a on bits 6..0, active-low
//   an          anodes, active-low, at most one low at a time
//   dp          decimal point cathode, active-low
//   frame_tick  one-cycle pulse following each shadow load
//   digit_idx   digit currently being scanned
module sseg_mux_nx #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int DEADTIME    = 16,
   parameter int DIM_BITS    = 4
) (
   input  logic                      clk,
   input  logic                      btnC,
   input  logic [4*DIGITS-1:0]       value,
   input  logic [DIGITS-1:0]         dp_in,
   input  logic                      blank_lz,
   input  logic [DIM_BITS-1:0]       brightness,
   output logic [6:0]                seg,
   output logic [DIGITS-1:0]         an,
   output logic                      dp,
   output logic                      frame_tick,
   output logic [$clog2(DIGITS)-1:0] digit_idx
);

   localparam int PC_W  = $clog2(REFRESH_DIV);
   localparam int IDX_W = $clog2(DIGITS);

   localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(REFRESH_DIV - 1);
   localparam logic [PC_W-1:0]  PC_DEAD  = PC_W'(DEADTIME);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   // Scan state
   logic [PC_W-1:0]       pc_reg, pc_next;
   logic [IDX_W-1:0]      idx_reg, idx_next;
   logic [DIM_BITS-1:0]   dc_reg;
   logic                  load_pending_reg;

   // Frame snapshot
   logic [4*DIGITS-1:0]   shadow_value_reg;
   logic [DIGITS-1:0]     shadow_dp_reg;
   logic                  shadow_lz_reg;

   // Registered pins
   logic [6:0]            seg_reg, seg_next;
   logic [DIGITS-1:0]     an_reg, an_next;
   logic                  dp_reg, dp_next;
   logic                  frame_tick_reg;
   logic [IDX_W-1:0]      digit_idx_reg;

   logic                  slot_end;
   logic                  frame_wrap;
   logic                  load_now;
   logic                  bright_en;

   logic [3:0]            nib_arr [DIGITS];
   logic [DIGITS-1:0]     blank_vec;
   logic [3:0]            cur_nib;
   logic                  cur_blank;
   logic                  cur_dp;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign slot_end   = (pc_reg == PC_LAST);
   assign frame_wrap = slot_end && (idx_reg == IDX_LAST);
   // The post-reset load guarantees the first frame is not drawn from zeros
   // for longer than one cycle.
   assign load_now   = frame_wrap || load_pending_reg;

   always_comb begin
      pc_next  = slot_end ? '0 : pc_reg + PC_W'(1);
      idx_next = idx_reg;
      if (slot_end) begin
         idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
      end
   end

   // Digit k is blanked when it and every digit above it are zero; the
   // rightmost digit is always shown so zero displays as "0".
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign nib_arr[gi] = shadow_value_reg[4*gi +: 4];
         if (gi == 0) begin : g_lsd
            assign blank_vec[gi] = 1'b0;
         end else begin : g_upper
            assign blank_vec[gi] = shadow_lz_reg &&
                                   (shadow_value_reg[4*DIGITS-1:4*gi] == '0);
         end
      end
   endgenerate

   assign cur_nib   = nib_arr[idx_reg];
   assign cur_blank = blank_vec[idx_reg];
   assign cur_dp    = shadow_dp_reg[idx_reg];

   // Full scale bypasses the compare so all-ones is truly 100% duty.
   assign bright_en = (&brightness) || (dc_reg < brightness);

   always_comb begin
      seg_next = 7'h7F;
      dp_next  = 1'b1;
      an_next  = '1;
      if (!cur_blank) begin
         seg_next = hex_to_seg(cur_nib);
         dp_next  = ~cur_dp;
         if ((pc_reg >= PC_DEAD) && bright_en) begin
            an_next[idx_reg] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge btnC) begin
      if (btnC) begin
         pc_reg           <= '0;
         idx_reg          <= '0;
         dc_reg           <= '0;
         load_pending_reg <= 1'b1;
         shadow_value_reg <= '0;
         shadow_dp_reg    <= '0;
         shadow_lz_reg    <= 1'b0;
         seg_reg          <= 7'h7F;
         an_reg           <= '1;
         dp_reg           <= 1'b1;
         frame_tick_reg   <= 1'b0;
         digit_idx_reg    <= '0;
      end else begin
         pc_reg           <= pc_next;
         idx_reg          <= idx_next;
         dc_reg           <= dc_reg + DIM_BITS'(1);
         load_pending_reg <= 1'b0;
         if (load_now) begin
            shadow_value_reg <= value;
            shadow_dp_reg    <= dp_in;
            shadow_lz_reg    <= blank_lz;
         end
         seg_reg          <= seg_next;
         an_reg           <= an_next;
         dp_reg           <= dp_next;
         frame_tick_reg   <= load_now;
         digit_idx_reg    <= idx_reg;
      end
   end

   assign seg        = seg_reg;
   assign an         = an_reg;
   assign dp         = dp_reg;
   assign frame_tick = frame_tick_reg;
   assign digit_idx  = digit_idx_reg;

endmodule

// File: tb/tb_sseg_mux_nx.sv
// tb_sseg_mux_nx -- self-checking bench for sseg_mux_nx.
//
// A behavioural model derives every expected pin value from the cycle
// number since reset release: slot, prescaler and dimming phase are plain
// divisions/modulos of that count, and the model keeps its own snapshot of
// the inputs taken at the load cycles.
module tb_sseg_mux_nx;

   localparam int D  = 4;
   localparam int RD = 8;
   localparam int DT = 2;
   localparam int DB = 2;
   localparam int FR = D * RD;

   logic        clk = 1'b0;
   logic        btnC = 1'b0;
   logic [15:0] value = 16'h0;
   logic [3:0]  dp_in = 4'h0;
   logic        blank_lz = 1'b0;
   logic [1:0]  brightness = 2'd0;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;
   logic        frame_tick;
   logic [1:0]  digit_idx;

   int total = 0;
   int bad   = 0;

   // model state
   int          e;
   logic [15:0] sh_val;
   logic [3:0]  sh_dp;
   logic        sh_lz;
   logic [14:0] expv;
   logic [6:0]  seg_tab [16];

   sseg_mux_nx #(
      .DIGITS(D), .REFRESH_DIV(RD), .DEADTIME(DT), .DIM_BITS(DB)
   ) dut (
      .clk(clk), .btnC(btnC), .value(value), .dp_in(dp_in),
      .blank_lz(blank_lz), .brightness(brightness), .seg(seg), .an(an),
      .dp(dp), .frame_tick(frame_tick), .digit_idx(digit_idx)
   );

   always #5 clk = ~clk;

   // Advance one clock; expv holds the pins the model predicts for the
   // cycle that follows this edge.
   task automatic tick();
      int p, s, d;
      logic blank, en, ld;
      logic [6:0] es;
      logic [3:0] ea;
      logic edp;
      @(posedge clk);
      e++;
      p = (e - 1) % RD;
      s = ((e - 1) / RD) % D;
      d = (e - 1) % (1 << DB);
      blank = sh_lz && (s != 0) && ((sh_val >> (4 * s)) == 16'h0);
      en = (brightness == 2'b11) || (d < int'(brightness));
      ld = (e == 1) || ((e - 1) % FR == FR - 1);
      es = blank ? 7'h7F : seg_tab[sh_val[4*s +: 4]];
      edp = blank ? 1'b1 : ~sh_dp[s];
      ea = 4'hF;
      if (p >= DT && !blank && en) ea[s] = 1'b0;
      expv = {es, ea, edp, ld, s[1:0]};
      if (ld) begin
         sh_val = value;
         sh_dp  = dp_in;
         sh_lz  = blank_lz;
      end
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      btnC = 1'b0;
      e = 0;
      sh_val = 16'h0;
      sh_dp = 4'h0;
      sh_lz = 1'b0;
   endtask

   task automatic test_reset();
      int lows [4];
      for (int k = 0; k < 4; k++) lows[k] = 0;
      #2 btnC = 1'b1;
      value = 16'h12AF; brightness = 2'd3; dp_in = 4'h0; blank_lz = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({seg, an, dp, frame_tick, digit_idx} !== {7'h7F, 4'hF, 1'b1, 1'b0, 2'd0}) begin
         bad++;
         $display("FAIL reset_pins got=%b want=%b", {seg, an, dp, frame_tick, digit_idx},
                  {7'h7F, 4'hF, 1'b1, 1'b0, 2'd0});
      end
      release_reset();
      for (int c = 0; c < FR; c++) begin
         tick();
         total++;
         if ({seg, an, dp, frame_tick, digit_idx} !== expv) begin
            bad++;
            $display("FAIL reset_frame e=%0d got=%b want=%b", e,
                     {seg, an, dp, frame_tick, digit_idx}, expv);
         end
         for (int k = 0; k < 4; k++) if (an[k] === 1'b0) lows[k]++;
      end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (lows[k] != 6) begin
            bad++;
            $display("FAIL reset_duty digit=%0d got=%0d want=6", k, lows[k]);
         end
      end
      $display("test_reset: first frame of 12AF checked, e=%0d", e);
   endtask

   task automatic test_frame_coherence();
      for (int c = 0; c < 2 * FR; c++) begin
         tick();
         if (e == FR + 12) value = 16'h0000;
         total++;
         if ({seg, an, dp, frame_tick, digit_idx} !== expv) begin
            bad++;
            $display("FAIL coherence e=%0d got=%b want=%b", e,
                     {seg, an, dp, frame_tick, digit_idx}, expv);
         end
         if (e == 2 * FR - 2) begin
            total++;
            if (seg !== 7'b1111001) begin
               bad++;
               $display("FAIL coherence_old e=%0d got=%b want=1111001", e, seg);
            end
         end
         if (e == 3 * FR - 2) begin
            total++;
            if (seg !== 7'b1000000) begin
               bad++;
               $display("FAIL coherence_new e=%0d got=%b want=1000000", e, seg);
            end
         end
      end
      $display("test_frame_coherence: mid-frame change held to wrap, e=%0d", e);
   endtask

   // Sets up inputs at a frame boundary, runs two frames and returns
   // per-digit anode-low and dp-low counts taken over the second frame,
   // where the new snapshot is fully in effect.
   task automatic test_blanking();
      int lows [4];
      logic [15:0] vals [2];
      int want_lows [2][4];
      vals[0] = 16'h0030;
      vals[1] = 16'h0000;
      want_lows[0] = '{6, 6, 0, 0};
      want_lows[1] = '{6, 0, 0, 0};
      blank_lz = 1'b1;
      for (int v = 0; v < 2; v++) begin
         value = vals[v];
         for (int k = 0; k < 4; k++) lows[k] = 0;
         for (int c = 0; c < 2 * FR; c++) begin
            tick();
            total++;
            if ({seg, an, dp, frame_tick, digit_idx} !== expv) begin
               bad++;
               $display("FAIL blanking e=%0d got=%b want=%b", e,
                        {seg, an, dp, frame_tick, digit_idx}, expv);
            end
            if (c >= FR) for (int k = 0; k < 4; k++) if (an[k] === 1'b0) lows[k]++;
         end
         for (int k = 0; k < 4; k++) begin
            total++;
            if (lows[k] != want_lows[v][k]) begin
               bad++;
               $display("FAIL blank_duty value=%h digit=%0d got=%0d want=%0d",
                        vals[v], k, lows[k], want_lows[v][k]);
            end
         end
         $display("test_blanking: value=%h lows=%0d %0d %0d %0d", vals[v],
                  lows[3], lows[2], lows[1], lows[0]);
      end
   endtask

   task automatic test_brightness();
      int lows;
      int want [4];
      want = '{0, 4, 8, 24};
      blank_lz = 1'b0;
      value = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
      for (int b = 0; b < 4; b++) begin
         brightness = 2'(b);
         lows = 0;
         for (int c = 0; c < 2 * FR; c++) begin
            tick();
            total++;
            if ({seg, an, dp, frame_tick, digit_idx} !== expv) begin
               bad++;
               $display("FAIL brightness e=%0d got=%b want=%b", e,
                        {seg, an, dp, frame_tick, digit_idx}, expv);
            end
            if (c >= FR && an !== 4'hF) lows++;
         end
         total++;
         if (lows != want[b]) begin
            bad++;
            $display("FAIL bright_duty level=%0d got=%0d want=%0d", b, lows, want[b]);
         end
         $display("test_brightness: level=%0d lit_cycles=%0d", b, lows);
      end
   endtask

   task automatic test_dp();
      int dlow;
      int want [2];
      logic [15:0] vals [2];
      logic lz [2];
      want = '{8, 0};
      vals[0] = 16'h4321;
      vals[1] = 16'h0005;
      lz = '{1'b0, 1'b1};
      brightness = 2'd3;
      dp_in = 4'b0100;
      for (int v = 0; v < 2; v++) begin
         value = vals[v];
         blank_lz = lz[v];
         dlow = 0;
         for (int c = 0; c < 2 * FR; c++) begin
            tick();
            total++;
            if ({seg, an, dp, frame_tick, digit_idx} !== expv) begin
               bad++;
               $display("FAIL dp e=%0d got=%b want=%b", e,
                        {seg, an, dp, frame_tick, digit_idx}, expv);
            end
            if (c >= FR && dp === 1'b0) begin
               dlow++;
               total++;
               if (digit_idx !== 2'd2) begin
                  bad++;
                  $display("FAIL dp_digit e=%0d got=%0d want=2", e, digit_idx);
               end
            end
         end
         total++;
         if (dlow != want[v]) begin
            bad++;
            $display("FAIL dp_count value=%h got=%0d want=%0d", vals[v], dlow, want[v]);
         end
         $display("test_dp: value=%h lz=%0d dp_low_cycles=%0d", vals[v], lz[v], dlow);
      end
      dp_in = 4'h0;
      blank_lz = 1'b0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 6 * FR; c++) begin
         tick();
         total++;
         if ({seg, an, dp, frame_tick, digit_idx} !== expv) begin
            bad++;
            $display("FAIL random e=%0d got=%b want=%b", e,
                     {seg, an, dp, frame_tick, digit_idx}, expv);
         end
         if ($urandom_range(0, 9) == 0) value = 16'($urandom);
         if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
         if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom);
         if ($urandom_range(0, 7) == 0) brightness = 2'($urandom);
         if ($urandom_range(0, 11) == 0) value = value & 16'h00FF;
      end
      $display("test_random: %0d random cycles, e=%0d", 6 * FR, e);
   endtask

   task automatic test_midreset();
      int lows [4];
      int guard;
      for (int k = 0; k < 4; k++) lows[k] = 0;
      brightness = 2'd3;
      blank_lz = 1'b0;
      value = 16'h5A5A;
      guard = 0;
      while ((e % FR) != 19 && guard < 2 * FR) begin
         tick();
         guard++;
      end
      total++;
      if ((e % FR) != 19) begin
         bad++;
         $display("FAIL midreset_align got=%0d want=19", e % FR);
      end
      #3 btnC = 1'b1;
      #1;
      total++;
      if ({seg, an, dp, frame_tick, digit_idx} !== {7'h7F, 4'hF, 1'b1, 1'b0, 2'd0}) begin
         bad++;
         $display("FAIL midreset_async got=%b want=%b", {seg, an, dp, frame_tick, digit_idx},
                  {7'h7F, 4'hF, 1'b1, 1'b0, 2'd0});
      end
      value = 16'hBEEF;
      @(posedge clk);
      #1;
      total++;
      if ({seg, an, dp, frame_tick, digit_idx} !== {7'h7F, 4'hF, 1'b1, 1'b0, 2'd0}) begin
         bad++;
         $display("FAIL midreset_hold got=%b want=%b", {seg, an, dp, frame_tick, digit_idx},
                  {7'h7F, 4'hF, 1'b1, 1'b0, 2'd0});
      end
      release_reset();
      for (int c = 0; c < FR + 4; c++) begin
         tick();
         total++;
         if ({seg, an, dp, frame_tick, digit_idx} !== expv) begin
            bad++;
            $display("FAIL midreset_restart e=%0d got=%b want=%b", e,
                     {seg, an, dp, frame_tick, digit_idx}, expv);
         end
         if (c < FR) for (int k = 0; k < 4; k++) if (an[k] === 1'b0) lows[k]++;
      end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (lows[k] != 6) begin
            bad++;
            $display("FAIL midreset_duty digit=%0d got=%0d want=6", k, lows[k]);
         end
      end
      $display("test_midreset: restart with BEEF checked, e=%0d", e);
   endtask

   initial begin
      seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
      seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
      seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
      seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
      seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
      seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
      seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
      seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
      e = 0;
      sh_val = 16'h0;
      sh_dp = 4'h0;
      sh_lz = 1'b0;
      expv = '0;
      test_reset();
      test_frame_coherence();
      test_blanking();
      test_brightness();
      test_dp();
      test_random();
      test_midreset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sseg_mux_nx.md
# sseg_mux_nx

Parametrised N-digit multiplexed seven-segment display driver. It is the successor to the fixed 4-digit clock-divider, digit-selector and hex-mux chain. The block takes a packed hex value, per-digit decimal points and display options, and time-multiplexes them onto active-low segment and anode pins. It adds frame-coherent input snapshotting, leading-zero blanking, PWM brightness control and anti-ghosting dead time. It sits directly behind the board pins in a top level, fed by switches or a counter datapath.

## Interface
- DIGITS, 4, number of digits/anodes (≥2)
- REFRESH_DIV, 100000, clk cycles per digit slot (≥ DEADTIME+2)
- DEADTIME, 16, cycles at start of each slot with all anodes off (≥1)
- DIM_BITS, 4, brightness resolution in bits
- clk  in  1  system clock; all state on rising edge
- btnC  in  1  reset; asynchronous, active-high
- value  in  4*DIGITS  hex nibbles; nibble k = value[4k+3:4k] drives digit k (digit 0 = rightmost)
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit
- blank_lz  in  1  1 = suppress leading zeros
- brightness  in  DIM_BITS  0 = dark, all-ones = full on
- seg  out  7  cathodes, active-low, bit6..0 = g,f,e,d,c,b,a
- an  out  DIGITS  anodes, active-low, one-hot-low when lit
- dp  out  1  decimal point cathode, active-low
- frame_tick  out  1  one-cycle pulse per shadow load
- digit_idx  out  $clog2(DIGITS)  currently scanned digit (debug)

## Operation
- Prescaler `pc` counts 0..REFRESH_DIV-1 and wraps. When `pc == REFRESH_DIV-1`, slot index `idx` advances on the next edge: 0→1→…→DIGITS-1→0.
- Shadow registers hold copies of value, dp_in and blank_lz. The display reads only the shadows.
- Shadow load edges:
  - the edge where `pc == REFRESH_DIV-1 && idx == DIGITS-1` (frame wrap);
  - the first clk edge after btnC deasserts (`load_pending` flag is set by reset and cleared by that load).
- frame_tick is registered. It is high for exactly the one cycle following each load edge.
- Decode is hex 0–F, in seg bit6..0 order: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Leading-zero blanking: with shadow blank_lz=1, digit k (k≥1) is blanked when its nibble and every nibble above it are 0. Digit 0 is never blanked, so a value of 0 shows "0".
- A blanked digit drives seg=1111111, dp=1 and an all-ones for the whole slot.
- Brightness uses a DIM_BITS counter `dc` that free-runs on every clk. Enable is `(brightness == all-ones) || (dc < brightness)`. brightness is sampled live, not shadowed.
- Anode for idx is driven low only when all three hold: `pc ≥ DEADTIME`, the digit is not blanked, and enable=1. Otherwise an is all ones.
- seg and dp always show the decode of the current idx unless the digit is blanked. dp = ~shadow dp_in[idx].

## Timing
- seg, an, dp, frame_tick and digit_idx are registered. Pins reflect the previous cycle's `pc/idx/dc` state, so latency is 1 clk.
- Reset values:
  - pins: an = all ones, seg = 1111111, dp = 1, frame_tick = 0, digit_idx = 0;
  - internal: pc = 0, dc = 0, idx = 0, shadows = 0, load_pending = 1.
- After btnC falls:
  - the load occurs on the 1st edge; frame_tick is high in cycle 1;
  - the first slot change is at edge REFRESH_DIV.
- Full frame = DIGITS*REFRESH_DIV cycles. Input changes mid-frame are invisible until the next frame wrap.
- A frame-wrap load and the slot-0 dead time coincide, so the new value first appears at `pc = DEADTIME` of slot 0.
- btnC asserted mid-frame immediately (asynchronously) forces all pins to their reset values, regardless of clk.
- brightness changes take effect at the next clk with no glitch beyond one cycle.

## Test plan
Bench parameters for all scenarios: DIGITS=4, REFRESH_DIV=8, DEADTIME=2, DIM_BITS=2.
- **Reset/load:** set value=16'h12AF and brightness=3, then release btnC → frame_tick=1 in cycle 1 only. Across one 32-cycle frame, an cycles 1110, 1101, 1011, 0111, each low for 6 of 8 cycles. seg shows 0001110 (F), 0001000 (A), 0100100 (2), 1111001 (1).
- **Frame coherence:** change value to 16'h0000 at cycle 12 → pins still show 12AF until the frame wrap. The next frame shows 0000.
- **Leading-zero blanking:** set blank_lz=1 and value=16'h0030 → digits 3 and 2 have an high for the whole slot. Digit 1 shows 0110000 (3) and digit 0 shows 1000000 (0). Then set value=0 → only digit 0 is lit, showing 0.
- **Brightness:**
  - brightness=0 → an is never low;
  - brightness=1 → an is low only when dc=0 within the non-dead portion of the slot;
  - brightness=3 → an is low for all 6 non-dead cycles.
- **Decimal point:** set dp_in=4'b0100 → dp=0 only while idx=2. For a blanked digit with dp_in set, dp stays 1.
- **Mid-operation reset:** pulse btnC at cycle 19, away from any clk edge → all pins return to reset values within the same cycle. After release the sequence restarts at idx=0 with a fresh load.
